// File: rtl/delayed_lif_neuron_if.sv
// Configuration, spike inputs and neuron outputs of the delayed LIF neuron,
// bundled with a driver-side (master) and neuron-side (slave) view.
interface delayed_lif_neuron_if #(
  parameter int M  = 8,
  parameter int W  = 2,
  parameter int P  = 6,
  parameter int DW = 3,
  parameter int RW = 5
);
  logic                 enable;
  logic                 delay_tick;
  logic [M-1:0]         input_spikes;
  logic [M*W-1:0]       weights;
  logic [M*DW-1:0]      delay_values;
  logic [M-1:0]         delay_en;
  logic [P-2:0]         threshold;
  logic [P-2:0]         decay;
  logic [RW-1:0]        refractory_period;
  logic                 reset_mode;
  logic signed [P-1:0]  membrane_potential_out;
  logic                 spike_out;
  logic                 refractory_active;

  modport master (
    output enable, delay_tick, input_spikes, weights, delay_values, delay_en,
           threshold, decay, refractory_period, reset_mode,
    input  membrane_potential_out, spike_out, refractory_active
  );

  modport slave (
    input  enable, delay_tick, input_spikes, weights, delay_values, delay_en,
           threshold, decay, refractory_period, reset_mode,
    output membrane_potential_out, spike_out, refractory_active
  );
endinterface

// File: rtl/delayed_lif_neuron.sv
// Leaky integrate-and-fire neuron with per-synapse programmable spike delay
// lines, saturating membrane potential and a counted refractory window.
//
// state      | meaning
// INTEGRATE  | accumulate weighted delayed spikes, leak, compare to threshold
// REFRACTORY | inputs and leak ignored, potential held, counter runs down
module delayed_lif_neuron #(
  parameter int M  = 8,
  parameter int W  = 2,
  parameter int P  = 6,
  parameter int DW = 3,
  parameter int RW = 5
) (
  input logic              clk,
  input logic              reset,
  delayed_lif_neuron_if.slave nif
);
  localparam int D  = (1 << DW) - 1;
  localparam int SW = P + $clog2(M) + W;
  localparam logic signed [SW-1:0] V_MAX = SW'((2 ** (P - 1)) - 1);
  localparam logic signed [SW-1:0] V_MIN = ~V_MAX;

  typedef enum logic {INTEGRATE, REFRACTORY} state_t;

  state_t                state_q, state_d;
  logic [RW-1:0]         cnt_q, cnt_d;
  logic signed [P-1:0]   v_q, v_d;
  logic                  spike_q, spike_d;
  logic [M-1:0][D-1:0]   hist_q, hist_d;

  logic [M-1:0]          tap;
  logic signed [SW-1:0]  sum, v_pre_full;
  logic signed [P:0]     v_pre, v_leak, dec_s, thr_s;
  logic                  fire;

  always_comb begin
    logic [DW-1:0] dv;
    tap = nif.input_spikes;
    for (int i = 0; i < M; i++) begin
      dv = nif.delay_values[i*DW +: DW];
      if (nif.delay_en[i] && dv != '0) tap[i] = hist_q[i][dv - DW'(1)];
    end
  end

  // Full-width accumulation so no intermediate sum can wrap before saturation.
  always_comb begin
    sum = '0;
    for (int i = 0; i < M; i++) begin
      if (tap[i]) sum = sum + {{(SW-W){nif.weights[i*W+W-1]}}, nif.weights[i*W +: W]};
    end
    v_pre_full = {{(SW-P){v_q[P-1]}}, v_q} + sum;
    if (v_pre_full > V_MAX)      v_pre = V_MAX[P:0];
    else if (v_pre_full < V_MIN) v_pre = V_MIN[P:0];
    else                         v_pre = v_pre_full[P:0];
  end

  always_comb begin
    dec_s = {2'b00, nif.decay};
    thr_s = {2'b00, nif.threshold};
    if (v_pre > dec_s)       v_leak = v_pre - dec_s;
    else if (v_pre < -dec_s) v_leak = v_pre + dec_s;
    else                     v_leak = '0;
    fire = (v_leak >= thr_s);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    v_d     = v_q;
    spike_d = 1'b0;
    hist_d  = hist_q;
    if (nif.enable) begin
      if (nif.delay_tick) begin
        for (int i = 0; i < M; i++) hist_d[i] = {hist_q[i][D-2:0], nif.input_spikes[i]};
      end
      case (state_q)
        INTEGRATE: begin
          if (fire) begin
            spike_d = 1'b1;
            v_d     = nif.reset_mode ? '0 : P'(v_leak - thr_s);
            if (nif.refractory_period != '0) begin
              state_d = REFRACTORY;
              cnt_d   = nif.refractory_period;
            end
          end else begin
            v_d = v_leak[P-1:0];
          end
        end
        REFRACTORY: begin
          cnt_d = cnt_q - RW'(1);
          if (cnt_q <= RW'(1)) state_d = INTEGRATE;
        end
        default: state_d = INTEGRATE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INTEGRATE;
      cnt_q   <= '0;
      v_q     <= '0;
      spike_q <= 1'b0;
      hist_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      v_q     <= v_d;
      spike_q <= spike_d;
      hist_q  <= hist_d;
    end
  end

  assign nif.membrane_potential_out = v_q;
  assign nif.spike_out              = spike_q;
  assign nif.refractory_active      = (state_q == REFRACTORY);
endmodule

// File: tb/tb_delayed_lif_neuron.sv
// Bench for delayed_lif_neuron: directed scenarios with fixed expectations plus
// randomized traffic compared against a queue-based behavioural neuron model.
module tb_delayed_lif_neuron;
  localparam int M  = 8;
  localparam int W  = 2;
  localparam int P  = 6;
  localparam int DW = 3;
  localparam int RW = 5;
  localparam int D  = (1 << DW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  delayed_lif_neuron_if #(.M(M), .W(W), .P(P), .DW(DW), .RW(RW)) bus ();
  delayed_lif_neuron #(.M(M), .W(W), .P(P), .DW(DW), .RW(RW)) dut (
    .clk(clk), .reset(reset), .nif(bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: history as a queue of past spike vectors (newest first).
  int           m_v;
  int           m_ref;
  logic         m_spk;
  logic [M-1:0] m_hist[$];

  task automatic model_step();
    logic [M-1:0] s;
    int dv, sum, vp, vl, dec, thr;
    if (reset) begin
      m_v = 0; m_ref = 0; m_spk = 1'b0;
      m_hist = {};
      for (int k = 0; k < D; k++) m_hist.push_back('0);
    end else if (!bus.enable) begin
      m_spk = 1'b0;
    end else begin
      for (int i = 0; i < M; i++) begin
        dv = int'(bus.delay_values[i*DW +: DW]);
        s[i] = (bus.delay_en[i] && dv != 0) ? m_hist[dv-1][i] : bus.input_spikes[i];
      end
      if (m_ref > 0) begin
        m_ref--;
        m_spk = 1'b0;
      end else begin
        sum = 0;
        for (int i = 0; i < M; i++) if (s[i]) sum += int'($signed(bus.weights[i*W +: W]));
        vp = m_v + sum;
        if (vp > 31) vp = 31;
        if (vp < -32) vp = -32;
        dec = int'(bus.decay);
        thr = int'(bus.threshold);
        if (vp > dec) vl = vp - dec;
        else if (vp < -dec) vl = vp + dec;
        else vl = 0;
        if (vl >= thr) begin
          m_spk = 1'b1;
          m_v = bus.reset_mode ? 0 : vl - thr;
          m_ref = int'(bus.refractory_period);
        end else begin
          m_spk = 1'b0;
          m_v = vl;
        end
      end
      if (bus.delay_tick) begin
        m_hist.push_front(bus.input_spikes);
        void'(m_hist.pop_back());
      end
    end
  endtask

  task automatic tick_edge();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    bus.enable = 1'b1; bus.delay_tick = 1'b0; bus.input_spikes = '0;
    bus.weights = '0; bus.delay_values = '0; bus.delay_en = '0;
    bus.threshold = 5'd31; bus.decay = '0; bus.refractory_period = '0;
    bus.reset_mode = 1'b1;
  endtask

  task automatic set_w(input int i, input int val);
    bus.weights[i*W +: W] = W'(val);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_edge();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    set_defaults();
    bus.input_spikes = '1; bus.delay_tick = 1'b1;
    for (int i = 0; i < M; i++) set_w(i, 1);
    reset = 1'b1;
    tick_edge();
    tick_edge();
    reset = 1'b0;
    n_checks++;
    if (bus.membrane_potential_out !== '0 || bus.spike_out !== 1'b0 || bus.refractory_active !== 1'b0)
      $display("FAIL reset_outputs: v=%0d spk=%b ref=%b required 0/0/0",
               bus.membrane_potential_out, bus.spike_out, bus.refractory_active);
    else n_pass++;
    // Every synapse reads a 1-tick delayed tap; they must all be cleared.
    bus.input_spikes = '0; bus.delay_tick = 1'b0;
    bus.delay_en = '1;
    for (int i = 0; i < M; i++) bus.delay_values[i*DW +: DW] = DW'(1);
    tick_edge();
    n_checks++;
    if (bus.membrane_potential_out !== '0)
      $display("FAIL reset_taps: v=%0d required 0", bus.membrane_potential_out);
    else n_pass++;
  endtask

  task automatic test_accumulate();
    int exp_v[6] = '{1, 2, 0, 1, 2, 0};
    logic exp_s[6] = '{0, 0, 1, 0, 0, 1};
    set_defaults();
    do_reset();
    set_w(0, 1);
    bus.threshold = 5'd3;
    bus.input_spikes[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick_edge();
      n_checks++;
      if (bus.membrane_potential_out !== P'(exp_v[k]))
        $display("FAIL accum_v[%0d]: got %0d required %0d", k, $signed(bus.membrane_potential_out), exp_v[k]);
      else n_pass++;
      n_checks++;
      if (bus.spike_out !== exp_s[k])
        $display("FAIL accum_spike[%0d]: got %b required %b", k, bus.spike_out, exp_s[k]);
      else n_pass++;
    end
  endtask

  task automatic test_delay();
    int exp_v[5] = '{0, 0, 0, 1, 1};
    set_defaults();
    do_reset();
    set_w(2, 1);
    bus.threshold = 5'd20;
    bus.delay_en[2] = 1'b1;
    bus.delay_values[2*DW +: DW] = DW'(3);
    bus.delay_tick = 1'b1;
    bus.input_spikes[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick_edge();
      bus.input_spikes[2] = 1'b0;
      n_checks++;
      if (bus.membrane_potential_out !== P'(exp_v[k]))
        $display("FAIL delay_v[%0d]: got %0d required %0d", k, $signed(bus.membrane_potential_out), exp_v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_saturation();
    int exp_v[6] = '{-8, -16, -24, -32, -32, -32};
    set_defaults();
    do_reset();
    for (int i = 0; i < M; i++) set_w(i, -1);
    bus.input_spikes = '1;
    for (int k = 0; k < 6; k++) begin
      tick_edge();
      n_checks++;
      if (bus.membrane_potential_out !== P'(exp_v[k]))
        $display("FAIL sat_v[%0d]: got %0d required %0d", k, $signed(bus.membrane_potential_out), exp_v[k]);
      else n_pass++;
    end
  endtask

  task automatic test_refractory();
    logic en[10]    = '{1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int   exp_v[10] = '{1, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic exp_s[10] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
    logic exp_r[10] = '{0, 1, 1, 0, 0, 1, 1, 1, 0, 0};
    set_defaults();
    do_reset();
    set_w(0, 1);
    bus.threshold = 5'd2;
    bus.refractory_period = RW'(2);
    bus.input_spikes[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.enable = en[k];
      tick_edge();
      n_checks++;
      if (bus.membrane_potential_out !== P'(exp_v[k]))
        $display("FAIL refr_v[%0d]: got %0d required %0d", k, $signed(bus.membrane_potential_out), exp_v[k]);
      else n_pass++;
      n_checks++;
      if (bus.spike_out !== exp_s[k])
        $display("FAIL refr_spike[%0d]: got %b required %b", k, bus.spike_out, exp_s[k]);
      else n_pass++;
      n_checks++;
      if (bus.refractory_active !== exp_r[k])
        $display("FAIL refr_active[%0d]: got %b required %b", k, bus.refractory_active, exp_r[k]);
      else n_pass++;
    end
  endtask

  task automatic test_subtract_reset();
    logic rs[4]     = '{0, 0, 1, 0};
    int   exp_v[4]  = '{2, 2, 0, 0};
    logic exp_s[4]  = '{1, 0, 0, 0};
    logic exp_r[4]  = '{1, 1, 0, 0};
    set_defaults();
    do_reset();
    bus.reset_mode = 1'b0;
    bus.threshold = 5'd3;
    bus.refractory_period = RW'(3);
    for (int i = 0; i < 5; i++) set_w(i, 1);
    bus.input_spikes = 8'h1F;
    for (int k = 0; k < 4; k++) begin
      reset = rs[k];
      if (k == 3) bus.input_spikes = '0;
      tick_edge();
      n_checks++;
      if (bus.membrane_potential_out !== P'(exp_v[k]) || bus.spike_out !== exp_s[k] ||
          bus.refractory_active !== exp_r[k])
        $display("FAIL subreset[%0d]: v=%0d spk=%b ref=%b required %0d/%b/%b", k,
                 $signed(bus.membrane_potential_out), bus.spike_out, bus.refractory_active,
                 exp_v[k], exp_s[k], exp_r[k]);
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    set_defaults();
    do_reset();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        bus.weights      = ($urandom);
        bus.delay_values = ($urandom);
        bus.delay_en     = ($urandom);
        bus.threshold    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        bus.decay        = 5'($urandom_range(0, 4));
        bus.refractory_period = RW'($urandom_range(0, 4));
        bus.reset_mode   = 1'($urandom);
      end
      bus.input_spikes = ($urandom);
      bus.enable       = ($urandom_range(0, 7) != 0);
      bus.delay_tick   = 1'($urandom);
      reset            = ($urandom_range(0, 99) == 0);
      tick_edge();
      n_checks++;
      if (bus.membrane_potential_out !== P'(m_v))
        $display("FAIL rand_v[%0d]: got %0d required %0d", k, $signed(bus.membrane_potential_out), m_v);
      else n_pass++;
      n_checks++;
      if (bus.spike_out !== m_spk)
        $display("FAIL rand_spike[%0d]: got %b required %b", k, bus.spike_out, m_spk);
      else n_pass++;
      n_checks++;
      if (bus.refractory_active !== (m_ref > 0))
        $display("FAIL rand_active[%0d]: got %b required %b", k, bus.refractory_active, (m_ref > 0));
      else n_pass++;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_defaults();
    @(posedge clk);
    #1;
    test_reset();
    test_accumulate();
    test_delay();
    test_saturation();
    test_refractory();
    test_subtract_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
